// File: rtl/panel_encoder_array.sv
// Multi-channel x4 quadrature encoder with input filtering, index capture and a word-addressed
// register slave. Define ENCODER_INDEX_EN to build the Z-input/index-capture path.
module panel_encoder_array #(
    parameter int CHANNELS    = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int FILT_CYCLES = 4,
    localparam int AW         = $clog2(CHANNELS) + 2
) (
    input  logic                PLD_MCLK,
    input  logic                EPL_RESETN,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    input  logic [CHANNELS-1:0] enc_z,
    input  logic [AW-1:0]       avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);

`ifdef ENCODER_INDEX_EN
    localparam int         NSIG     = 3;
    localparam logic [3:0] CtrlMask = 4'b1111;
`else
    localparam int         NSIG     = 2;
    localparam logic [3:0] CtrlMask = 4'b1101;
`endif
    localparam int            FW       = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0] FiltLast = FW'(FILT_CYCLES - 1);

    // Per-channel signal vectors: bit0 = A, bit1 = B, bit2 = Z (index builds only).
    logic [NSIG-1:0]      raw      [CHANNELS];
    logic [NSIG-1:0]      s1_d     [CHANNELS];
    logic [NSIG-1:0]      s1_q     [CHANNELS];
    logic [NSIG-1:0]      s2_d     [CHANNELS];
    logic [NSIG-1:0]      s2_q     [CHANNELS];
    logic [NSIG-1:0]      filt_d   [CHANNELS];
    logic [NSIG-1:0]      filt_q   [CHANNELS];
    logic [NSIG-1:0]      prev_d   [CHANNELS];
    logic [NSIG-1:0]      prev_q   [CHANNELS];
    logic [FW-1:0]        fcnt_d   [CHANNELS][NSIG];
    logic [FW-1:0]        fcnt_q   [CHANNELS][NSIG];
    logic [CNT_WIDTH-1:0] pos_d    [CHANNELS];
    logic [CNT_WIDTH-1:0] pos_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] ipos_d   [CHANNELS];
    logic [CNT_WIDTH-1:0] ipos_q   [CHANNELS];
    logic [3:0]           ctrl_d   [CHANNELS];
    logic [3:0]           ctrl_q   [CHANNELS];
    logic [CHANNELS-1:0]  err_d, err_q;
    logic [CHANNELS-1:0]  idx_d, idx_q;
    logic [CHANNELS-1:0]  dir_d, dir_q;
    logic                 irq_d, irq_q;
    logic [31:0]          rdata_d, rdata_q;

    logic unused_inputs;
    assign unused_inputs = ^{enc_z, avs_writedata};

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            raw[c]    = '0;
            raw[c][0] = enc_a[c];
            raw[c][1] = enc_b[c];
`ifdef ENCODER_INDEX_EN
            raw[c][2] = enc_z[c];
`endif
        end
    end

    always_comb begin
        int         ch_sel;
        logic [1:0] reg_sel;
        logic [1:0] old_idx;
        logic [1:0] new_idx;
        logic [1:0] delta;
        logic       step;
        logic       illegal;
        logic       up;
        logic       z_rise;
        logic       wr;

        ch_sel  = int'(avs_address >> 2);
        reg_sel = avs_address[1:0];
        irq_d   = 1'b0;
        rdata_d = avs_read ? 32'd0 : rdata_q;

        for (int c = 0; c < CHANNELS; c++) begin
            s1_d[c]   = raw[c];
            s2_d[c]   = s1_q[c];
            prev_d[c] = filt_q[c];
            filt_d[c] = filt_q[c];
            for (int s = 0; s < NSIG; s++) begin
                fcnt_d[c][s] = '0;
                if (s2_q[c][s] != filt_q[c][s]) begin
                    if (fcnt_q[c][s] == FiltLast) begin
                        filt_d[c][s] = s2_q[c][s];
                    end else begin
                        fcnt_d[c][s] = fcnt_q[c][s] + 1'b1;
                    end
                end
            end

            // Map Gray {A,B} onto a 0..3 ring so the step is a 2-bit difference.
            old_idx = {prev_q[c][0], prev_q[c][0] ^ prev_q[c][1]};
            new_idx = {filt_q[c][0], filt_q[c][0] ^ filt_q[c][1]};
            delta   = new_idx - old_idx;
            step    = (delta == 2'd1) || (delta == 2'd3);
            illegal = (delta == 2'd2);
            up      = (delta == 2'd1) ^ ctrl_q[c][2];
`ifdef ENCODER_INDEX_EN
            z_rise  = filt_q[c][2] & ~prev_q[c][2];
`else
            z_rise  = 1'b0;
`endif
            wr = avs_write && (ch_sel == c);

            pos_d[c] = pos_q[c];
            if (wr && reg_sel == 2'd0) begin
                pos_d[c] = avs_writedata[CNT_WIDTH-1:0];
            end else if (z_rise && ctrl_q[c][1]) begin
                pos_d[c] = '0;
            end else if (step && ctrl_q[c][0]) begin
                pos_d[c] = up ? pos_q[c] + 1'b1 : pos_q[c] - 1'b1;
            end

            ipos_d[c] = z_rise ? pos_q[c] : ipos_q[c];
            dir_d[c]  = (step && ctrl_q[c][0]) ? up : dir_q[c];
            // Clearing write loses against a same-cycle set event.
            err_d[c]  = (err_q[c] & ~(wr && reg_sel == 2'd2 && avs_writedata[0])) | illegal;
            idx_d[c]  = (idx_q[c] & ~(wr && reg_sel == 2'd2 && avs_writedata[1])) | z_rise;
            ctrl_d[c] = (wr && reg_sel == 2'd3) ? (avs_writedata[3:0] & CtrlMask) : ctrl_q[c];

            if (avs_read && ch_sel == c) begin
                case (reg_sel)
                    2'd0:    rdata_d = 32'($signed(pos_q[c]));
                    2'd1:    rdata_d = 32'($signed(ipos_q[c]));
                    2'd2:    rdata_d = {29'd0, dir_q[c], idx_q[c], err_q[c]};
                    default: rdata_d = {28'd0, ctrl_q[c]};
                endcase
            end

            irq_d = irq_d | (ctrl_q[c][3] & (err_q[c] | idx_q[c]));
        end
    end

    always_ff @(posedge PLD_MCLK or negedge EPL_RESETN) begin
        if (!EPL_RESETN) begin
            for (int c = 0; c < CHANNELS; c++) begin
                s1_q[c]   <= '0;
                s2_q[c]   <= '0;
                filt_q[c] <= '0;
                prev_q[c] <= '0;
                for (int s = 0; s < NSIG; s++) begin
                    fcnt_q[c][s] <= '0;
                end
                pos_q[c]  <= '0;
                ipos_q[c] <= '0;
                ctrl_q[c] <= '0;
            end
            err_q   <= '0;
            idx_q   <= '0;
            dir_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                s1_q[c]   <= s1_d[c];
                s2_q[c]   <= s2_d[c];
                filt_q[c] <= filt_d[c];
                prev_q[c] <= prev_d[c];
                for (int s = 0; s < NSIG; s++) begin
                    fcnt_q[c][s] <= fcnt_d[c][s];
                end
                pos_q[c]  <= pos_d[c];
                ipos_q[c] <= ipos_d[c];
                ctrl_q[c] <= ctrl_d[c];
            end
            err_q   <= err_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: doc/panel_encoder_array.md
# panel_encoder_array

Multi-channel quadrature position encoder for the front-panel subsystem, replacing single-channel encoders behind the serial host bus. Each channel synchronises and glitch-filters its A/B/Z inputs, decodes x4 quadrature into a signed wrapping position counter, latches position on index, and flags illegal transitions. A word-addressed register slave exposes per-channel position, index capture, status and control, plus one combined level interrupt.

## Interface
- CHANNELS, 2: encoder channel count, 1..16.
- CNT_WIDTH, 16: position counter width, 8..32; read data sign-extended to 32 bits.
- FILT_CYCLES, 4: consecutive stable samples required before a filtered input changes, 1..255.
- PLD_MCLK  in  1  system clock.
- EPL_RESETN  in  1  reset; asynchronous, active-low.
- enc_a  in  CHANNELS  quadrature A per channel, asynchronous.
- enc_b  in  CHANNELS  quadrature B per channel, asynchronous.
- enc_z  in  CHANNELS  index per channel, asynchronous, active-high.
- avs_address  in  clog2(CHANNELS)+2  word address; bits [1:0] select register, upper bits select channel.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- irq  out  1  level interrupt.

## Operation
- Registers per channel (offset): 0 POSITION (R/W); 1 INDEX_POS (R); 2 STATUS (R, write-1-to-clear); 3 CTRL (R/W).
- STATUS: bit0 ERR sticky illegal transition; bit1 IDX sticky index seen; bit2 DIR last step direction (1 = up), read-only.
- CTRL: bit0 EN count enable; bit1 CLR_ON_IDX; bit2 INV swaps count direction; bit3 IRQ_EN. Unused bits read 0.
- Input path per signal: 2-flop synchroniser, then filter counter; filtered value takes the synchronised value after it has differed for FILT_CYCLES consecutive clocks; any agreeing sample resets the counter.
- Decode compares filtered {A,B} with previous: Gray step 00->01->11->10->00 = +1 (−1 reverse, both negated when INV). No change = hold. Both bits changed = illegal: no count, ERR set.
- Counting only when EN=1; ERR and IDX detection active regardless of EN.
- POSITION wraps two's complement at CNT_WIDTH (max+1 -> min, min−1 -> max).
- Index: rising edge of filtered Z captures current POSITION (pre-step value of that cycle) into INDEX_POS, sets IDX; if CLR_ON_IDX, POSITION becomes 0.
- Priority same cycle: bus write to POSITION > index clear > quadrature step.
- STATUS W1C versus same-cycle set event: set wins.
- irq = OR over channels of IRQ_EN & (ERR | IDX).
- Writes to out-of-range channel ignored; reads return 0.

## Timing
- Reset: POSITION, INDEX_POS, STATUS, CTRL = 0 (counting disabled), filters load 0 with counters cleared, avs_readdata = 0, irq = 0.
- Input edge to POSITION update: 2 (sync) + FILT_CYCLES (filter) + 1 (decode/count) clocks; FILT_CYCLES=4 gives 7.
- Pulses shorter than FILT_CYCLES clocks after sync are rejected entirely.
- avs_readdata valid the clock after avs_read; holds until next read. No wait states; write takes effect at the clock edge of avs_write.
- Read and write same cycle to same register: read returns the pre-write value.
- irq asserts one clock after the flag/enable condition, deasserts one clock after clear.
- Reset mid-operation clears everything asynchronously; first count after release needs full latency.

## Configuration
- ENCODER_INDEX_EN defined: synchroniser, filter and edge logic on enc_z; INDEX_POS, IDX, CLR_ON_IDX behave as above.
- Not defined: enc_z ignored, no Z logic built; INDEX_POS reads 0, IDX reads 0, CLR_ON_IDX write ignored and reads 0.

## Test plan
- CHANNELS=2, FILT_CYCLES=4, ch0 EN=1; 12 forward Gray steps, 10 clocks apart -> POSITION reads 12, DIR=1; 5 reverse -> 7, DIR=0; first step visible 7 clocks after edge.
- CNT_WIDTH=16, write POSITION=0x7FFF, one forward step -> reads 0xFFFF8000; one reverse -> 0x00007FFF.
- Glitches of 3 clocks on ch1 A -> POSITION unchanged; 5-clock pulse -> accepted; AB 00->11 -> no count, ERR=1, irq=1 with IRQ_EN; write STATUS=1 -> ERR=0, irq=0.
- ENCODER_INDEX_EN defined, CLR_ON_IDX=1, POSITION=37: Z rising -> INDEX_POS=37, POSITION=0, IDX=1; same cycle as forward step -> POSITION=0.
- Bus write POSITION=100 same cycle as step -> 100; INV=1 forward steps decrement; EN=0 steps ignored but illegal still sets ERR.
- Assert EPL_RESETN low mid-count -> all registers 0, readdata 0, irq 0 immediately; recount after release correct.
